// File: rtl/main_data_reservoir_ctrl_if.sv
// main_data_reservoir_ctrl_if: byte-in, frame-request and byte-out signals of the bit-reservoir controller
interface main_data_reservoir_ctrl_if #(parameter int AW = 11);
  logic [7:0]  axiid;
  logic        axiiv;
  logic        si_valid;
  logic [8:0]  main_data_begin;
  logic [13:0] md_bits;
  logic [7:0]  axiod;
  logic        axiov;
  logic        axior;
  logic        frame_done;
  logic        underflow_err;
  logic        abort_err;
  logic [AW:0] hist_count;
  logic        busy;
  modport master (
    output axiid, axiiv, si_valid, main_data_begin, md_bits, axior,
    input  axiod, axiov, frame_done, underflow_err, abort_err, hist_count, busy
  );
  modport slave (
    input  axiid, axiiv, si_valid, main_data_begin, md_bits, axior,
    output axiod, axiov, frame_done, underflow_err, abort_err, hist_count, busy
  );
endinterface

// File: rtl/main_data_reservoir_ctrl.sv
// main_data_reservoir_ctrl: MP3 bit-reservoir buffer that replays each frame's main data from main_data_begin
module main_data_reservoir_ctrl #(
  parameter int DEPTH = 2048,
  parameter int AW    = $clog2(DEPTH)
) (
  input logic                        clk,
  input logic                        rst,
  main_data_reservoir_ctrl_if.slave  md_if
);
  typedef enum logic [1:0] {IDLE, CHECK, STREAM} state_e;
  logic [7:0]    mem [DEPTH];
  state_e        state_q;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q, start_q, start_d, nxt_ptr;
  logic [AW:0]   hist_q;
  logic [8:0]    mdb_q;
  logic [10:0]   need_q, need_d, rem_q;
  logic [7:0]    axiod_q;
  logic          axiov_q, done_q, uf_q, ab_q;
  assign start_d = wr_ptr_q - AW'(md_if.main_data_begin);
  assign need_d  = 11'((15'(md_if.md_bits) + 15'd7) >> 3);
  assign nxt_ptr = rd_ptr_q + AW'(1);
  assign md_if.axiod         = axiod_q;
  assign md_if.axiov         = axiov_q;
  assign md_if.frame_done    = done_q;
  assign md_if.underflow_err = uf_q;
  assign md_if.abort_err     = ab_q;
  assign md_if.hist_count    = hist_q;
  assign md_if.busy          = state_q != IDLE;
  always_ff @(posedge clk)
    if (md_if.axiiv) mem[wr_ptr_q] <= md_if.axiid;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      start_q  <= '0;
      hist_q   <= '0;
      mdb_q    <= '0;
      need_q   <= '0;
      rem_q    <= '0;
      axiod_q  <= '0;
      axiov_q  <= 1'b0;
      done_q   <= 1'b0;
      uf_q     <= 1'b0;
      ab_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      uf_q   <= 1'b0;
      ab_q   <= 1'b0;
      if (md_if.axiiv) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
        if (hist_q != (AW+1)'(DEPTH)) hist_q <= hist_q + (AW+1)'(1);
      end
      if (md_if.si_valid) begin
        ab_q    <= state_q != IDLE;
        axiov_q <= 1'b0;
        start_q <= start_d;
        need_q  <= need_d;
        mdb_q   <= md_if.main_data_begin;
        state_q <= CHECK;
      end else begin
        case (state_q)
          CHECK: begin
            if ((AW+1)'(mdb_q) > hist_q) begin
              uf_q    <= 1'b1;
              state_q <= IDLE;
            end else if (need_q == '0) begin
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              rd_ptr_q <= start_q;
              rem_q    <= need_q;
              state_q  <= STREAM;
            end
          end
          STREAM: begin
            // rd_ptr tracks the byte on axiod; a byte at wr_ptr is not yet written
            if (axiov_q && md_if.axior) begin
              rem_q <= rem_q - 11'd1;
              if (rem_q == 11'd1) begin
                done_q  <= 1'b1;
                axiov_q <= 1'b0;
                state_q <= IDLE;
              end else begin
                rd_ptr_q <= nxt_ptr;
                axiov_q  <= nxt_ptr != wr_ptr_q;
                axiod_q  <= mem[nxt_ptr];
              end
            end else if (!axiov_q && rd_ptr_q != wr_ptr_q) begin
              axiov_q <= 1'b1;
              axiod_q <= mem[rd_ptr_q];
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_main_data_reservoir_ctrl.sv
// tb_main_data_reservoir_ctrl: table, directed and randomized checks against an absolute-byte-index model
module tb_main_data_reservoir_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  main_data_reservoir_ctrl_if #(.AW(11)) md();
  main_data_reservoir_ctrl #(.DEPTH(2048), .AW(11)) dut (.clk(clk), .rst(rst), .md_if(md));
  typedef struct {
    int n_pre; int mdb; int bits; int exp_hist; int exp_uf; int exp_n; int exp_first;
  } vec_t;
  vec_t tbl [9];
  logic [7:0] wdata [int];
  logic [7:0] got [$];
  int wcnt, errs, checks, n_done, n_uf, n_ab, n_v;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic step();
    logic hold;
    logic [7:0] held;
    hold = md.axiov && !md.axior && !md.si_valid;
    held = md.axiod;
    if (md.axiov && md.axior) got.push_back(md.axiod);
    @(posedge clk);
    #1;
    if (md.frame_done) n_done++;
    if (md.underflow_err) n_uf++;
    if (md.abort_err) n_ab++;
    if (md.axiov) n_v++;
    if (hold) begin
      chk("hold_valid", int'(md.axiov), 1);
      chk("hold_data", int'(md.axiod), int'(held));
    end
  endtask
  task automatic wr(input bit en, input bit rnd);
    logic [7:0] v;
    v = rnd ? 8'($urandom) : 8'(wcnt);
    md.axiiv = en;
    md.axiid = v;
    if (en) begin
      wdata[wcnt] = v;
      wcnt++;
    end
  endtask
  task automatic do_reset();
    rst = 1'b0;
    md.axiiv = 0; md.axiid = 0; md.si_valid = 0; md.main_data_begin = 0; md.md_bits = 0; md.axior = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    wcnt = 0;
    wdata.delete();
  endtask
  task automatic prewrite(input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      wr(1'b1, rnd);
      step();
    end
    md.axiiv = 1'b0;
  endtask
  task automatic frame(input int mdb, input int bits, input bit rnd, input int rdy_pct, input int wr_pct);
    got.delete();
    n_done = 0; n_uf = 0; n_ab = 0; n_v = 0;
    md.si_valid = 1'b1;
    md.main_data_begin = 9'(mdb);
    md.md_bits = 14'(bits);
    md.axiiv = 1'b0;
    md.axior = $urandom_range(99) < rdy_pct;
    step();
    md.si_valid = 1'b0;
    for (int c = 0; c < 5000 && n_done == 0 && n_uf == 0; c++) begin
      wr($urandom_range(99) < wr_pct, rnd);
      md.axior = $urandom_range(99) < rdy_pct;
      step();
    end
    md.axiiv = 1'b0;
    md.axior = 1'b0;
    if (n_done == 0 && n_uf == 0) chk("frame_timeout", 0, 1);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    tbl[0] = '{100, 0,   80,   100,  0, 10,  100};
    tbl[1] = '{300, 40,  320,  300,  0, 40,  4};
    tbl[2] = '{20,  21,  80,   20,   1, 0,   0};
    tbl[3] = '{20,  20,  13,   20,   0, 2,   0};
    tbl[4] = '{50,  10,  0,    50,   0, 0,   0};
    tbl[5] = '{0,   0,   8,    0,    0, 1,   0};
    tbl[6] = '{600, 511, 4000, 600,  0, 500, 89};
    tbl[7] = '{20,  20,  160,  20,   0, 20,  0};
    tbl[8] = '{2100, 511, 80,  2048, 0, 10,  53};
    errs = 0; checks = 0;
    do_reset();
    rst = 1'b0;
    #3;
    chk("rst_axiov", int'(md.axiov), 0);
    chk("rst_axiod", int'(md.axiod), 0);
    chk("rst_done", int'(md.frame_done), 0);
    chk("rst_uf", int'(md.underflow_err), 0);
    chk("rst_abort", int'(md.abort_err), 0);
    chk("rst_hist", int'(md.hist_count), 0);
    chk("rst_busy", int'(md.busy), 0);
    for (int t = 0; t < 9; t++) begin
      bit ok;
      do_reset();
      prewrite(tbl[t].n_pre, 1'b0);
      chk($sformatf("tbl%0d_hist", t), int'(md.hist_count), tbl[t].exp_hist);
      frame(tbl[t].mdb, tbl[t].bits, 1'b0, 50, 100);
      chk($sformatf("tbl%0d_uf", t), n_uf, tbl[t].exp_uf);
      chk($sformatf("tbl%0d_done", t), n_done, tbl[t].exp_uf != 0 ? 0 : 1);
      chk($sformatf("tbl%0d_nbytes", t), got.size(), tbl[t].exp_n);
      if (tbl[t].exp_n == 0) chk($sformatf("tbl%0d_novalid", t), n_v, 0);
      ok = 1'b1;
      foreach (got[k]) if (got[k] != 8'(tbl[t].exp_first + k)) ok = 1'b0;
      chk($sformatf("tbl%0d_order", t), int'(ok), 1);
    end
    do_reset();
    prewrite(10, 1'b0);
    got.delete(); n_done = 0;
    md.si_valid = 1'b1; md.main_data_begin = 9'd5; md.md_bits = 14'd16; md.axior = 1'b1;
    step();
    md.si_valid = 1'b0;
    chk("lat_busy", int'(md.busy), 1);
    chk("lat_t1_valid", int'(md.axiov), 0);
    step();
    chk("lat_t2_valid", int'(md.axiov), 0);
    step();
    chk("lat_t3_valid", int'(md.axiov), 1);
    chk("lat_t3_data", int'(md.axiod), 5);
    for (int c = 0; c < 20 && n_done == 0; c++) step();
    chk("lat_done", n_done, 1);
    chk("lat_nbytes", got.size(), 2);
    if (got.size() == 2) chk("lat_byte1", int'(got[1]), 6);
    do_reset();
    prewrite(20, 1'b0);
    n_uf = 0; n_v = 0;
    md.si_valid = 1'b1; md.main_data_begin = 9'd21; md.md_bits = 14'd80; md.axior = 1'b1;
    step();
    md.si_valid = 1'b0;
    chk("uf_t1", int'(md.underflow_err), 0);
    step();
    chk("uf_t2", int'(md.underflow_err), 1);
    step();
    chk("uf_t3", int'(md.underflow_err), 0);
    chk("uf_idle", int'(md.busy), 0);
    repeat (3) step();
    chk("uf_novalid", n_v, 0);
    do_reset();
    prewrite(100, 1'b0);
    got.delete(); n_ab = 0; n_done = 0;
    md.si_valid = 1'b1; md.main_data_begin = 9'd50; md.md_bits = 14'd400; md.axior = 1'b1;
    step();
    md.si_valid = 1'b0;
    for (int c = 0; c < 30 && got.size() < 5; c++) step();
    chk("ab_pre_valid", int'(md.axiov), 1);
    md.axior = 1'b0; md.si_valid = 1'b1; md.main_data_begin = 9'd10; md.md_bits = 14'd24;
    step();
    md.si_valid = 1'b0;
    chk("ab_pulse", int'(md.abort_err), 1);
    chk("ab_drop", int'(md.axiov), 0);
    got.delete();
    md.axior = 1'b1;
    for (int c = 0; c < 30 && n_done == 0; c++) step();
    chk("ab_done", n_done, 1);
    chk("ab_count", n_ab, 1);
    chk("ab_nbytes", got.size(), 3);
    if (got.size() == 3) begin
      chk("ab_b0", int'(got[0]), 90);
      chk("ab_b2", int'(got[2]), 92);
    end
    do_reset();
    prewrite(200, 1'b1);
    for (int f = 0; f < 25; f++) begin
      int w, h, mdb, bits, need, bad;
      w = wcnt;
      h = w > 2048 ? 2048 : w;
      mdb = $urandom_range(0, h + 3 > 511 ? 511 : h + 3);
      bits = $urandom_range(3) == 0 ? ($urandom_range(1) == 0 ? 0 : 13) : $urandom_range(1, 800);
      need = (bits + 7) / 8;
      frame(mdb, bits, 1'b1, 50, 70);
      chk($sformatf("rnd%0d_uf", f), n_uf, mdb > h ? 1 : 0);
      chk($sformatf("rnd%0d_done", f), n_done, mdb > h ? 0 : 1);
      chk($sformatf("rnd%0d_nbytes", f), got.size(), mdb > h ? 0 : need);
      bad = 0;
      foreach (got[k]) if (got[k] != wdata[w - mdb + k]) bad++;
      chk($sformatf("rnd%0d_bad_bytes", f), bad, 0);
    end
    do_reset();
    prewrite(3000, 1'b1);
    chk("sat_hist", int'(md.hist_count), 2048);
    frame(511, 160, 1'b1, 50, 0);
    chk("sat_nbytes", got.size(), 20);
    begin
      int bad;
      bad = 0;
      foreach (got[k]) if (got[k] != wdata[3000 - 511 + k]) bad++;
      chk("sat_bad_bytes", bad, 0);
    end
    md.si_valid = 1'b1; md.main_data_begin = 9'd100; md.md_bits = 14'd800; md.axior = 1'b0;
    step();
    md.si_valid = 1'b0;
    for (int c = 0; c < 10 && !md.axiov; c++) step();
    chk("mid_valid", int'(md.axiov), 1);
    rst = 1'b0;
    #1;
    chk("mid_axiov", int'(md.axiov), 0);
    chk("mid_axiod", int'(md.axiod), 0);
    chk("mid_busy", int'(md.busy), 0);
    chk("mid_hist", int'(md.hist_count), 0);
    chk("mid_pulses", int'({md.frame_done, md.underflow_err, md.abort_err}), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
